// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through in one cycle, runs the
// data-memory request/ready handshake for loads and stores, and stalls upstream meanwhile.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic              mem_unsigned_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              stallreq_o,
  output logic              wb_valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic              lat_store;
  logic              lat_uns;
  logic [4:0]        lat_wd;
  logic              lat_wreg;
  logic [3:0]        lat_be;
  logic [DATA_W-1:0] lat_wdata;

  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              bad_access;
  logic              issue;
  logic              in_access;
  logic [3:0]        be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] load_data;

  assign addr = wdata_i[ADDR_W-1:0];
  assign size = mem_op_i[1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bad_access = 1'b0;
    be_next    = 4'b1111;
    wdata_next = store_data_i;
    case (size)
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        bad_access = addr[0];
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{store_data_i[15:0]}};
      end
      2'b10:   bad_access = (addr[1:0] != 2'b00);
      default: bad_access = 1'b1;
    endcase
  end

  always_comb begin
    load_data = mem_rdata_i;
    case (lat_size)
      2'b00: begin
        load_data[7:0]  = mem_rdata_i[8*lat_addr[1:0] +: 8];
        load_data[31:8] = {24{~lat_uns & load_data[7]}};
      end
      2'b01: begin
        load_data[15:0]  = mem_rdata_i[16*lat_addr[1] +: 16];
        load_data[31:16] = {16{~lat_uns & load_data[15]}};
      end
      default: load_data = mem_rdata_i;
    endcase
  end

  assign issue      = (state == S_IDLE) && valid_i && mem_op_i[3] && !bad_access;
  assign in_access  = (state == S_ACCESS) && !rst;
  assign stallreq_o = !rst && ((state == S_ACCESS) ? !mem_ready_i : issue);

  // Memory port is driven only from the latched copy, so it is stable until ready.
  assign mem_req_o   = in_access;
  assign mem_we_o    = in_access && lat_store;
  assign mem_addr_o  = in_access ? {lat_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be_o    = in_access ? lat_be : 4'b0000;
  assign mem_wdata_o = in_access ? lat_wdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wb_valid_o <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      misalign_o <= 1'b0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_store  <= 1'b0;
      lat_uns    <= 1'b0;
      lat_wd     <= '0;
      lat_wreg   <= 1'b0;
      lat_be     <= '0;
      lat_wdata  <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i && !mem_op_i[3]) begin
            wb_valid_o <= 1'b1;
            wd_o       <= wd_i;
            wreg_o     <= wreg_i;
            wdata_o    <= wdata_i;
          end else if (valid_i && bad_access) begin
            wb_valid_o <= 1'b1;
            wd_o       <= wd_i;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            misalign_o <= 1'b1;
          end else if (issue) begin
            state     <= S_ACCESS;
            lat_addr  <= addr;
            lat_size  <= size;
            lat_store <= mem_op_i[2];
            lat_uns   <= mem_unsigned_i;
            lat_wd    <= wd_i;
            lat_wreg  <= wreg_i;
            lat_be    <= be_next;
            lat_wdata <= wdata_next;
          end
        end
        S_ACCESS: begin
          if (mem_ready_i) begin
            state      <= S_IDLE;
            wb_valid_o <= 1'b1;
            wd_o       <= lat_wd;
            wreg_o     <= lat_store ? 1'b0 : lat_wreg;
            wdata_o    <= lat_store ? '0 : load_data;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus random ops against a
// behavioural byte-lane model of loads, stores and alignment rules.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [4:0]  wd_in;
  logic        wreg_in;
  logic [31:0] alu_res;
  logic [3:0]  mem_op;
  logic        mem_uns;
  logic [31:0] store_data;
  logic        stallreq_o;
  logic        wb_valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] OP_ALU = 4'b0000;
  localparam logic [3:0] OP_LB  = 4'b1000;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SH  = 4'b1101;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid),
    .wd_i           (wd_in),
    .wreg_i         (wreg_in),
    .wdata_i        (alu_res),
    .mem_op_i       (mem_op),
    .mem_unsigned_i (mem_uns),
    .store_data_i   (store_data),
    .stallreq_o     (stallreq_o),
    .wb_valid_o     (wb_valid_o),
    .wd_o           (wd_o),
    .wreg_o         (wreg_o),
    .wdata_o        (wdata_o),
    .misalign_o     (misalign_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ready_i    (mem_ready),
    .mem_rdata_i    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: an access covers n = 2**size bytes starting at byte a.
  function automatic logic [31:0] model_load(input logic [31:0] a, input int size_code,
                                             input logic uns, input logic [31:0] rd);
    int n;
    longint v;
    n = 1 << size_code;
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (!uns && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input int size_code);
    logic [3:0] be;
    int n;
    n  = 1 << size_code;
    be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= a % 4) && (i < a % 4 + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input int size_code);
    logic [31:0] w;
    int n;
    n = 1 << size_code;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'((d >> (8 * (i % n))) & 32'hFF);
    return w;
  endfunction

  // Presents one instruction and follows it until its result reaches write-back.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic uns,
                       input logic [31:0] sd, input logic [4:0] wd, input logic wr,
                       input int waits, input logic [31:0] rd);
    int  n;
    bit  legal;
    bit  is_store;
    n        = 1 << op[1:0];
    legal    = (op[1:0] != 2'b11) && (a % n == 0);
    is_store = op[3] && op[2];
    @(negedge clk);
    valid = 1'b1; mem_op = op; alu_res = a; mem_uns = uns; store_data = sd;
    wd_in = wd; wreg_in = wr; mem_ready = 1'b0; mem_rdata = $urandom;
    #1;
    check("stall_issue", stallreq_o, 32'(op[3] && legal));
    check("req_idle", mem_req_o, 0);
    @(posedge clk); #1;
    if (!op[3] || !legal) begin
      check("wb_valid_1cyc", wb_valid_o, 1);
      check("wd_1cyc", wd_o, wd);
      check("wreg_1cyc", wreg_o, op[3] ? 0 : wr);
      check("wdata_1cyc", wdata_o, op[3] ? 0 : a);
      check("misalign", misalign_o, 32'(op[3]));
    end else begin
      check("wb_valid_issue", wb_valid_o, 0);
      for (int k = 0; k <= waits; k++) begin
        @(negedge clk);
        mem_ready = (k == waits);
        mem_rdata = (k == waits) ? rd : $urandom;
        #1;
        check("mem_req", mem_req_o, 1);
        check("mem_we", mem_we_o, 32'(is_store));
        check("mem_addr", mem_addr_o, a & ~32'd3);
        check("mem_be", mem_be_o, model_be(a, op[1:0]));
        if (is_store) check("mem_wdata", mem_wdata_o, model_wdata(sd, op[1:0]));
        check("stall_access", stallreq_o, 32'(k != waits));
        @(posedge clk); #1;
        if (k < waits) check("wb_valid_wait", wb_valid_o, 0);
      end
      check("wb_valid_mem", wb_valid_o, 1);
      check("wd_mem", wd_o, wd);
      check("wreg_mem", wreg_o, is_store ? 0 : wr);
      check("wdata_mem", wdata_o, is_store ? 0 : model_load(a, op[1:0], uns, rd));
      check("misalign_mem", misalign_o, 0);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("idle_wb_valid", wb_valid_o, 0);
    check("idle_misalign", misalign_o, 0);
    check("idle_req", mem_req_o, 0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; wd_in = '0; wreg_in = 1'b0; alu_res = '0; mem_op = '0;
    mem_uns = 1'b0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wd", wd_o, 0);
    check("rst_wreg", wreg_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_stall", stallreq_o, 0);
    check("rst_be", mem_be_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // ALU pass-through
    do_op(OP_ALU, 32'h1234, 1'b0, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    idle_cycle();
    // LB from the top byte lane, signed then unsigned
    do_op(OP_LB, 32'h103, 1'b0, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_0000);
    check("lb_signed", wdata_o, 32'hFFFF_FF80);
    do_op(OP_LB, 32'h103, 1'b1, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_0000);
    check("lb_unsigned", wdata_o, 32'h0000_0080);
    idle_cycle();
    // SH to the upper half, ready immediately
    do_op(OP_SH, 32'h202, 1'b0, 32'hAAAA_BEEF, 5'd0, 1'b0, 0, 32'h0);
    // Misaligned LW, then an ALU op accepted immediately after
    do_op(OP_LW, 32'h101, 1'b0, 32'h0, 5'd9, 1'b1, 0, 32'h0);
    do_op(OP_ALU, 32'hCAFE, 1'b0, 32'h0, 5'd10, 1'b1, 0, 32'h0);
    // LW then ADD back-to-back; the trailing idle proves no duplicate
    do_op(OP_LW, 32'h400, 1'b0, 32'h0, 5'd11, 1'b1, 2, 32'h1357_9BDF);
    do_op(OP_ALU, 32'h55AA, 1'b0, 32'h0, 5'd12, 1'b1, 0, 32'h0);
    idle_cycle();

    // Reset in the second ACCESS cycle abandons the load
    @(negedge clk);
    valid = 1'b1; mem_op = OP_LW; alu_res = 32'h300; wd_in = 5'd13; wreg_in = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    check("rst_acc_req", mem_req_o, 0);
    check("rst_acc_stall", stallreq_o, 0);
    check("rst_acc_wb_valid", wb_valid_o, 0);
    check("rst_acc_wdata", wdata_o, 0);
    check("rst_acc_wd", wd_o, 0);
    check("rst_acc_be", mem_be_o, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();
    do_op(OP_LW, 32'h300, 1'b0, 32'h0, 5'd13, 1'b1, 1, 32'hDEAD_BEEF);

    // Random mix of ALU, legal, misaligned and illegal-size accesses
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  op;
      logic [31:0] a;
      a  = $urandom;
      op = ($urandom_range(0, 3) == 0) ? OP_ALU
           : {1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      if (op[3] && $urandom_range(0, 1) == 1) a = a & ~32'd3;
      do_op(op, a, 1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
